xbox_mem_bank: RTL and testbench
================================

// Module: xbox_mem_bank
// PURPOSE
// - Banked SRAM sitting directly downstream of the XBOX accelerator memory-master port; it serves the xlr_mem_* requests.
// - A second host port (SW/DMA loader side) preloads operands and reads back results.
// - The accelerator port has absolute priority and a fixed 1-cycle read latency, so the accelerator never stalls.
// - The host port uses a req/gnt handshake and is refused on a same-bank collision.
// PARAMETERS
// NUM_MEMS            2   number of independent memory instances (banks)
// LOG2_LINES_PER_MEM  8   address bits per bank; a line is 8 x 32-bit words (256 bits)
// CNT_W               16  width of the saturating collision counter
// PORTS
// clk             in   1                          system clock, all logic on posedge
// rst             in   1                          synchronous reset, active-high
// xlr_mem_addr    in   [NUM_MEMS][LOG2_LINES_PER_MEM]  accelerator line address per bank
// xlr_mem_wdata   in   [NUM_MEMS][8][32]          accelerator write data per bank
// xlr_mem_be      in   [NUM_MEMS][32]             byte enables; bit i -> byte i of line (word w = bytes 4w..4w+3)
// xlr_mem_rd      in   [NUM_MEMS]                 accelerator read strobe per bank
// xlr_mem_wr      in   [NUM_MEMS]                 accelerator write strobe per bank
// xlr_mem_rdata   out  [NUM_MEMS][8][32]          accelerator read data, valid 1 cycle after xlr_mem_rd
// host_mem_sel    in   $clog2(NUM_MEMS)           host target bank
// host_mem_addr   in   LOG2_LINES_PER_MEM         host line address
// host_mem_wdata  in   [8][32]                    host write data
// host_mem_be     in   32                         host byte enables
// host_mem_rd     in   1                          host read request
// host_mem_wr     in   1                          host write request
// host_mem_gnt    out  1                          combinational grant; request completes in a cycle with gnt=1
// host_mem_rvalid out  1                          host read data valid, 1 cycle after a granted read
// host_mem_rdata  out  [8][32]                    host read data
// coll_cnt        out  CNT_W                      saturating count of cycles in which the host was refused
// BEHAVIOUR
// - Storage: per bank, 2**LOG2_LINES_PER_MEM lines of 256 bits. Array contents are NOT reset.
// - Reset values of outputs:
//   - xlr_mem_rdata = 0, host_mem_rdata = 0, host_mem_rvalid = 0, coll_cnt = 0.
//   - host_mem_gnt is 0 while rst = 1.
// - Accelerator port, per bank b, every cycle:
//   - wr: for each i with be[i] = 1, write byte i of wdata to line addr at posedge. be = 0 writes nothing.
//   - rd: xlr_mem_rdata[b] = line addr on the next cycle (registered).
//   - No rd: xlr_mem_rdata[b] holds its last value.
//   - rd and wr in the same cycle, same address: rdata returns the OLD line (read-before-write).
// - Host port:
//   - Request = host_mem_rd | host_mem_wr.
//   - host_mem_gnt = request & ~rst & ~(xlr_mem_rd[sel] | xlr_mem_wr[sel]).
//   - Granted write: byte-enabled write, as on the accelerator port. Granted read: host_mem_rdata / host_mem_rvalid on the next cycle.
//   - host_mem_rvalid is a single-cycle pulse per granted read. host_mem_rdata holds between reads.
//   - host_mem_rd and host_mem_wr both set: treated as a write plus a read-before-write of the same line.
//   - Refused request: no array or output effect; the host must hold the request until granted.
// - Collision counter: coll_cnt increments by 1 per cycle with request & ~host_mem_gnt & ~rst, and saturates at all-ones.
// - Banks are independent: host on bank a and accelerator on bank b (a != b) both proceed in the same cycle.
// - Address wrap: none. The address width exactly spans the bank. host_mem_sel >= NUM_MEMS is never granted and is counted as a collision.
// - Reset mid-operation:
//   - A read issued in the cycle rst rises produces no rvalid and no rdata update.
//   - Writes are suppressed while rst = 1.
//   - Array contents are preserved.
// TESTING
// T1 host writes line 0 bank0 = {A=1,2,3,4; B=5,6,7,8}, be=FFFFFFFF, idle xlr -> gnt=1; host read next cycle returns same, rvalid pulse 1 cycle
// T2 xlr_mem_rd[0]=1 addr 0 -> xlr_mem_rdata[0] = {8,7,6,5,4,3,2,1} (word7..0) exactly 1 cycle later
// T3 xlr write addr 1 bank0 wdata words 19,22,43,50, be=0000FFFF -> words 0..3 updated, words 4..7 keep prior value
// T4 host wr bank0 while xlr_mem_rd[0]=1 for 3 cycles -> gnt=0 for 3 cycles, coll_cnt=3, write lands on 4th cycle; host on bank1 same time -> gnt=1, coll_cnt unchanged
// T5 xlr rd+wr same addr, old=0, new=all 0xA5 -> rdata=0 next cycle, rdata=all 0xA5 on following read
// T6 assert rst 1 cycle after a granted host read -> rvalid stays 0, all outputs 0; line data intact on post-reset read

Source files
------------

// File: rtl/xbox_mem_bank.sv
// xbox_mem_bank: banked line SRAM shared by the XBOX accelerator memory master and a host loader port.
// Latency: accelerator and host reads both return registered data one cycle after the request.
// Backpressure: the accelerator is never stalled; host requests get gnt=0 on a same-bank collision and must be held.
//
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   xlr_mem_*         - per-bank accelerator port (addr, wdata, byte enables, rd, wr, registered rdata)
//   host_mem_*        - host port: bank select, addr, wdata, be, rd/wr request, combinational gnt,
//                       rvalid pulse and held rdata
//   coll_cnt          - saturating count of cycles in which a host request was refused
module xbox_mem_bank #(
  parameter int NUM_MEMS           = 2,
  parameter int LOG2_LINES_PER_MEM = 8,
  parameter int CNT_W              = 16,
  localparam int SEL_W             = (NUM_MEMS > 1) ? $clog2(NUM_MEMS) : 1,
  localparam int LINES             = 2 ** LOG2_LINES_PER_MEM
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0]   xlr_mem_addr,
  input  logic [NUM_MEMS-1:0][7:0][31:0]                xlr_mem_wdata,
  input  logic [NUM_MEMS-1:0][31:0]                     xlr_mem_be,
  input  logic [NUM_MEMS-1:0]                           xlr_mem_rd,
  input  logic [NUM_MEMS-1:0]                           xlr_mem_wr,
  output logic [NUM_MEMS-1:0][7:0][31:0]                xlr_mem_rdata,
  input  logic [SEL_W-1:0]                              host_mem_sel,
  input  logic [LOG2_LINES_PER_MEM-1:0]                 host_mem_addr,
  input  logic [7:0][31:0]                              host_mem_wdata,
  input  logic [31:0]                                   host_mem_be,
  input  logic                                          host_mem_rd,
  input  logic                                          host_mem_wr,
  output logic                                          host_mem_gnt,
  output logic                                          host_mem_rvalid,
  output logic [7:0][31:0]                              host_mem_rdata,
  output logic [CNT_W-1:0]                              coll_cnt
);

  // Line storage; deliberately not reset so contents survive a reset pulse.
  logic [255:0] mem [NUM_MEMS][LINES];

  logic host_req;
  logic sel_ok;
  logic bank_busy;
  logic host_wr_go;
  logic host_rd_go;

  assign host_req = host_mem_rd | host_mem_wr;
  // An out-of-range bank select is never granted and counts as a collision.
  assign sel_ok   = (int'(host_mem_sel) < NUM_MEMS);

  // Host loses to any accelerator activity (rd or wr) on the selected bank.
  always_comb begin
    bank_busy = 1'b0;
    for (int b = 0; b < NUM_MEMS; b++) begin
      if (host_mem_sel == SEL_W'(b)) begin
        bank_busy = xlr_mem_rd[b] | xlr_mem_wr[b];
      end
    end
  end

  assign host_mem_gnt = host_req & ~rst & sel_ok & ~bank_busy;
  assign host_wr_go   = host_mem_gnt & host_mem_wr;
  assign host_rd_go   = host_mem_gnt & host_mem_rd;

  // Array writes. Host and accelerator never write the same bank in one cycle
  // because the grant excludes that case. Reads below sample the pre-edge
  // contents, which gives read-before-write on the same line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int b = 0; b < NUM_MEMS; b++) begin
        for (int i = 0; i < 32; i++) begin
          if (xlr_mem_wr[b] && xlr_mem_be[b][i]) begin
            mem[b][xlr_mem_addr[b]][8*i +: 8] <= xlr_mem_wdata[b][i/4][8*(i%4) +: 8];
          end
          if (host_wr_go && host_mem_sel == SEL_W'(b) && host_mem_be[i]) begin
            mem[b][host_mem_addr][8*i +: 8] <= host_mem_wdata[i/4][8*(i%4) +: 8];
          end
        end
      end
    end
  end

  // Accelerator read data: registered, held when no read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      xlr_mem_rdata <= '0;
    end else begin
      for (int b = 0; b < NUM_MEMS; b++) begin
        if (xlr_mem_rd[b]) begin
          xlr_mem_rdata[b] <= mem[b][xlr_mem_addr[b]];
        end
      end
    end
  end

  // Host read data: single-cycle rvalid pulse, data held between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      host_mem_rvalid <= 1'b0;
      host_mem_rdata  <= '0;
    end else begin
      host_mem_rvalid <= host_rd_go;
      if (host_rd_go) begin
        host_mem_rdata <= mem[host_mem_sel][host_mem_addr];
      end
    end
  end

  // Refused-cycle counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      coll_cnt <= '0;
    end else if (host_req && !host_mem_gnt && !(&coll_cnt)) begin
      coll_cnt <= coll_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_xbox_mem_bank.sv
// Directed bench for xbox_mem_bank: host/accelerator reads and writes, byte enables,
// collisions and the refusal counter, read-before-write, and reset mid-operation.
module tb_xbox_mem_bank;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [1:0][7:0]        xlr_mem_addr;
  logic [1:0][7:0][31:0]  xlr_mem_wdata;
  logic [1:0][31:0]       xlr_mem_be;
  logic [1:0]             xlr_mem_rd;
  logic [1:0]             xlr_mem_wr;
  logic [1:0][7:0][31:0]  xlr_mem_rdata;
  logic [0:0]             host_mem_sel;
  logic [7:0]             host_mem_addr;
  logic [7:0][31:0]       host_mem_wdata;
  logic [31:0]            host_mem_be;
  logic                   host_mem_rd;
  logic                   host_mem_wr;
  logic                   host_mem_gnt;
  logic                   host_mem_rvalid;
  logic [7:0][31:0]       host_mem_rdata;
  logic [15:0]            coll_cnt;

  int n_pass  = 0;
  int n_total = 0;

  xbox_mem_bank dut (
    .clk             (clk),
    .rst             (rst),
    .xlr_mem_addr    (xlr_mem_addr),
    .xlr_mem_wdata   (xlr_mem_wdata),
    .xlr_mem_be      (xlr_mem_be),
    .xlr_mem_rd      (xlr_mem_rd),
    .xlr_mem_wr      (xlr_mem_wr),
    .xlr_mem_rdata   (xlr_mem_rdata),
    .host_mem_sel    (host_mem_sel),
    .host_mem_addr   (host_mem_addr),
    .host_mem_wdata  (host_mem_wdata),
    .host_mem_be     (host_mem_be),
    .host_mem_rd     (host_mem_rd),
    .host_mem_wr     (host_mem_wr),
    .host_mem_gnt    (host_mem_gnt),
    .host_mem_rvalid (host_mem_rvalid),
    .host_mem_rdata  (host_mem_rdata),
    .coll_cnt        (coll_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one clock and settle 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [255:0] l0, l1_init, l1_exp, d2, d3, a5;

  initial begin
    l0      = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    l1_init = {32'd107, 32'd106, 32'd105, 32'd104, 32'd103, 32'd102, 32'd101, 32'd100};
    l1_exp  = {32'd107, 32'd106, 32'd105, 32'd104, 32'd50, 32'd43, 32'd22, 32'd19};
    d2      = {8{32'h1234_5678}};
    d3      = {8{32'hCAFE_0003}};
    a5      = {32{8'hA5}};

    rst = 1'b1;
    xlr_mem_addr = '0; xlr_mem_wdata = '0; xlr_mem_be = '0; xlr_mem_rd = '0; xlr_mem_wr = '0;
    host_mem_sel = '0; host_mem_addr = '0; host_mem_wdata = '0; host_mem_be = '0;
    host_mem_rd = 1'b1; host_mem_wr = 1'b0;

    // Reset: no grant while rst, outputs zero, refused cycles under reset not counted.
    #1;
    chk("gnt_in_reset", 256'(host_mem_gnt), 256'd0);
    tick(); tick();
    chk("rst_xlr_rdata", xlr_mem_rdata, 256'd0);
    chk("rst_host_rdata", host_mem_rdata, 256'd0);
    chk("rst_rvalid", 256'(host_mem_rvalid), 256'd0);
    chk("rst_coll_cnt", 256'(coll_cnt), 256'd0);
    host_mem_rd = 1'b0;
    rst = 1'b0;
    tick();

    // T1: host write line 0 bank 0, then read back.
    host_mem_wr = 1'b1; host_mem_sel = 1'b0; host_mem_addr = 8'd0;
    host_mem_wdata = l0; host_mem_be = 32'hFFFF_FFFF;
    #1;
    chk("t1_wr_gnt", 256'(host_mem_gnt), 256'd1);
    tick();
    host_mem_wr = 1'b0; host_mem_rd = 1'b1;
    #1;
    chk("t1_rd_gnt", 256'(host_mem_gnt), 256'd1);
    tick();
    host_mem_rd = 1'b0;
    chk("t1_rvalid", 256'(host_mem_rvalid), 256'd1);
    chk("t1_rdata", host_mem_rdata, l0);
    tick();
    chk("t1_rvalid_pulse", 256'(host_mem_rvalid), 256'd0);
    chk("t1_rdata_hold", host_mem_rdata, l0);

    // T2: accelerator read of line 0, one cycle latency, then held.
    xlr_mem_rd[0] = 1'b1; xlr_mem_addr[0] = 8'd0;
    tick();
    xlr_mem_rd[0] = 1'b0;
    chk("t2_xlr_rdata", xlr_mem_rdata[0], l0);
    tick();
    chk("t2_xlr_hold", xlr_mem_rdata[0], l0);

    // T3: partial accelerator write, lower four words only.
    host_mem_wr = 1'b1; host_mem_addr = 8'd1; host_mem_wdata = l1_init;
    tick();
    host_mem_wr = 1'b0;
    xlr_mem_wr[0] = 1'b1; xlr_mem_addr[0] = 8'd1; xlr_mem_be[0] = 32'h0000_FFFF;
    xlr_mem_wdata[0] = {{4{32'hDEAD_BEEF}}, 32'd50, 32'd43, 32'd22, 32'd19};
    tick();
    xlr_mem_wr[0] = 1'b0; xlr_mem_rd[0] = 1'b1;
    tick();
    xlr_mem_rd[0] = 1'b0;
    chk("t3_partial_wr", xlr_mem_rdata[0], l1_exp);

    // T4: host refused three cycles while the accelerator reads bank 0.
    xlr_mem_rd[0] = 1'b1; xlr_mem_addr[0] = 8'd5;
    host_mem_wr = 1'b1; host_mem_sel = 1'b0; host_mem_addr = 8'd2; host_mem_wdata = d2;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("t4_refused_%0d", c), 256'(host_mem_gnt), 256'd0);
      tick();
    end
    chk("t4_coll_cnt", 256'(coll_cnt), 256'd3);
    xlr_mem_rd[0] = 1'b0;
    #1;
    chk("t4_gnt_after", 256'(host_mem_gnt), 256'd1);
    tick();
    // Other bank proceeds while the accelerator is busy on bank 0.
    xlr_mem_rd[0] = 1'b1;
    host_mem_sel = 1'b1; host_mem_addr = 8'd3; host_mem_wdata = d3;
    #1;
    chk("t4_bank1_gnt", 256'(host_mem_gnt), 256'd1);
    tick();
    xlr_mem_rd[0] = 1'b0; host_mem_wr = 1'b0;
    chk("t4_coll_unchanged", 256'(coll_cnt), 256'd3);
    host_mem_rd = 1'b1; host_mem_sel = 1'b0; host_mem_addr = 8'd2;
    tick();
    chk("t4_landed_bank0", host_mem_rdata, d2);
    host_mem_sel = 1'b1; host_mem_addr = 8'd3;
    tick();
    host_mem_rd = 1'b0;
    chk("t4_landed_bank1", host_mem_rdata, d3);

    // T5: read-before-write on the same line, then a be=0 write changes nothing.
    xlr_mem_wr[0] = 1'b1; xlr_mem_addr[0] = 8'd4; xlr_mem_be[0] = 32'hFFFF_FFFF; xlr_mem_wdata[0] = '0;
    tick();
    xlr_mem_rd[0] = 1'b1; xlr_mem_wdata[0] = a5;
    tick();
    chk("t5_old_line", xlr_mem_rdata[0], 256'd0);
    xlr_mem_rd[0] = 1'b0; xlr_mem_be[0] = 32'h0; xlr_mem_wdata[0] = '0;
    tick();
    xlr_mem_wr[0] = 1'b0; xlr_mem_rd[0] = 1'b1;
    tick();
    xlr_mem_rd[0] = 1'b0;
    chk("t5_new_line", xlr_mem_rdata[0], a5);

    // T6: granted read, then reset asserted with a read still requested.
    host_mem_rd = 1'b1; host_mem_sel = 1'b0; host_mem_addr = 8'd1;
    tick();
    chk("t6_pre_rvalid", 256'(host_mem_rvalid), 256'd1);
    rst = 1'b1;
    #1;
    chk("t6_gnt_rst", 256'(host_mem_gnt), 256'd0);
    tick();
    chk("t6_rvalid", 256'(host_mem_rvalid), 256'd0);
    chk("t6_host_rdata", host_mem_rdata, 256'd0);
    chk("t6_xlr_rdata", xlr_mem_rdata, 256'd0);
    chk("t6_coll_cnt", 256'(coll_cnt), 256'd0);
    rst = 1'b0; host_mem_addr = 8'd0;
    tick();
    host_mem_addr = 8'd1;
    chk("t6_intact_l0", host_mem_rdata, l0);
    tick();
    host_mem_rd = 1'b0;
    chk("t6_intact_l1", host_mem_rdata, l1_exp);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
